// File: rtl/uart_rxs.sv
// 8N1 UART receiver that assembles BYTES consecutive bytes into one packet, MSB byte first.
// Framing errors and inter-byte idle timeouts discard the partial packet.
module uart_rxs #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int BYTES        = 2,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic               uartrx,
    output logic [BYTES*8-1:0] odats,
    output logic               uart_rxs_done,
    output logic               rx_err,
    output logic [1:0]         dbg_state
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int HALF       = BIT_CYCLES / 2;
    localparam int IDLE_LIMIT = TIMEOUT_BITS * BIT_CYCLES;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t             state, state_next;
    logic               rx_s1, rx_s2, rx_prev;
    logic               v1, v2;
    logic [31:0]        cnt;
    logic [31:0]        idle_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;
    logic [1:0]         byte_cnt;
    logic [BYTES*8-1:0] pkt, pkt_next;
    logic               fall, half_tick, bit_tick;
    logic               start_det, byte_ok, frame_err;

    assign dbg_state = state;

    // rx_prev only becomes 1 from a real line sample (v2 set), so a line held
    // low across reset release never looks like a falling edge.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            v1      <= 1'b0;
            v2      <= 1'b0;
            rx_prev <= 1'b0;
        end else begin
            rx_s1   <= uartrx;
            rx_s2   <= rx_s1;
            v1      <= 1'b1;
            v2      <= v1;
            rx_prev <= rx_s2 & v2;
        end
    end

    assign fall      = rx_prev & ~rx_s2;
    assign half_tick = (cnt == 32'(HALF - 1));
    assign bit_tick  = (cnt == 32'(BIT_CYCLES - 1));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_det  = 1'b0;
        byte_ok    = 1'b0;
        frame_err  = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) begin
                    state_next = S_START;
                    start_det  = 1'b1;
                end
            end
            S_START: begin
                if (half_tick) state_next = rx_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (bit_tick && bit_idx == 3'd7) state_next = S_STOP;
            end
            S_STOP: begin
                if (bit_tick) begin
                    state_next = S_IDLE;
                    byte_ok    = rx_s2;
                    frame_err  = ~rx_s2;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pkt_next = pkt;
        for (int i = 0; i < BYTES; i++) begin
            if (byte_cnt == 2'(BYTES - 1 - i)) pkt_next[i*8 +: 8] = shreg;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            idle_cnt      <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            byte_cnt      <= '0;
            pkt           <= '0;
            odats         <= '0;
            uart_rxs_done <= 1'b0;
            rx_err        <= 1'b0;
        end else begin
            uart_rxs_done <= 1'b0;
            rx_err        <= 1'b0;

            if (state == S_IDLE || state_next != state || (state == S_DATA && bit_tick))
                cnt <= '0;
            else
                cnt <= cnt + 32'd1;

            if (start_det) bit_idx <= '0;
            if (state == S_DATA && bit_tick) begin
                shreg   <= {rx_s2, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end

            if (byte_ok) begin
                if (byte_cnt == 2'(BYTES - 1)) begin
                    odats         <= pkt_next;
                    uart_rxs_done <= 1'b1;
                    byte_cnt      <= '0;
                end else begin
                    pkt      <= pkt_next;
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end else if (frame_err) begin
                rx_err   <= 1'b1;
                byte_cnt <= '0;
            end

            // Inter-byte timeout: drop a partial packet silently.
            if (state == S_IDLE && byte_cnt != 2'd0 && !start_det) begin
                if (idle_cnt == 32'(IDLE_LIMIT - 1)) begin
                    idle_cnt <= '0;
                    byte_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 32'd1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rxs.sv
// Directed bench for uart_rxs: a byte-level packet model predicts every done/odats/rx_err
// event; a per-cycle compare process checks the DUT against it.
module tb_uart_rxs;

    localparam int CLK_FREQ     = 1_000_000;
    localparam int BAUD         = 100_000;
    localparam int BYTES        = 2;
    localparam int TIMEOUT_BITS = 20;
    localparam int BC           = CLK_FREQ / BAUD;
    localparam int W            = BYTES * 8;

    logic         sys_clk = 1'b0;
    logic         rst_n   = 1'b0;
    logic         uartrx  = 1'b1;
    logic [W-1:0] odats;
    logic         uart_rxs_done;
    logic         rx_err;
    logic [1:0]   dbg_state;

    uart_rxs #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .BYTES       (BYTES),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .uartrx       (uartrx),
        .odats        (odats),
        .uart_rxs_done(uart_rxs_done),
        .rx_err       (rx_err),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    always #5 sys_clk = ~sys_clk;

    int errors   = 0;
    int checks   = 0;
    int done_seen = 0;
    int err_seen  = 0;
    int err_exp   = 0;
    bit running   = 1'b0;

    // packet model
    logic [W-1:0] exp_q[$];
    logic [W-1:0] pkt_acc = '0;
    int           pkt_n   = 0;
    logic [W-1:0] cur_odats = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
    endtask

    // abort_bit >= 0 pulses reset half-way through that data bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int abort_bit);
        uartrx = 1'b0;
        tick(BC);
        for (int i = 0; i < 8; i++) begin
            uartrx = b[i];
            if (i == abort_bit) begin
                tick(BC / 2);
                do_reset();
                pkt_acc = '0;
                pkt_n   = 0;
                uartrx  = 1'b1;
                return;
            end
            tick(BC);
        end
        // Model is updated before the stop bit so the expectation exists before the DUT pulses.
        if (stop_bit) begin
            pkt_acc = {pkt_acc[W-9:0], b};
            pkt_n++;
            if (pkt_n == BYTES) begin
                exp_q.push_back(pkt_acc);
                pkt_n = 0;
            end
        end else begin
            err_exp++;
            pkt_n = 0;
        end
        uartrx = stop_bit;
        tick(BC);
    endtask

    task automatic idle_bits(input int n);
        uartrx = 1'b1;
        tick(n * BC);
        if (n >= TIMEOUT_BITS) pkt_n = 0;
    endtask

    // scoreboard / compare process
    always @(negedge sys_clk) begin
        if (running) begin
            if (!rst_n) begin
                cur_odats = '0;
                check("reset_odats", 32'(odats), 32'h0);
                check("reset_done", 32'(uart_rxs_done), 32'h0);
                check("reset_err", 32'(rx_err), 32'h0);
            end else begin
                check("done_err_exclusive", 32'(uart_rxs_done & rx_err), 32'h0);
                if (uart_rxs_done) begin
                    done_seen++;
                    check("done_expected", 32'(exp_q.size() != 0), 32'h1);
                    if (exp_q.size() != 0) cur_odats = exp_q.pop_front();
                end
                if (rx_err) begin
                    err_seen++;
                    check("rx_err_expected", 32'(err_exp != 0), 32'h1);
                    if (err_exp != 0) err_exp--;
                end
                check("odats", 32'(odats), 32'(cur_odats));
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int d0, e0;

    initial begin
        running = 1'b1;
        // Line low across reset release must not start a byte.
        uartrx = 1'b0;
        tick(5);
        check("por_odats", 32'(odats), 32'h0);
        check("por_done", 32'(uart_rxs_done), 32'h0);
        rst_n = 1'b1;
        tick(30);
        uartrx = 1'b1;
        tick(30);
        check("low_at_release_err", 32'(err_seen), 32'h0);
        check("low_at_release_done", 32'(done_seen), 32'h0);

        // Back-to-back 0x12, 0x34
        d0 = done_seen; e0 = err_seen;
        send_byte(8'h12, 1'b1, -1);
        send_byte(8'h34, 1'b1, -1);
        idle_bits(2);
        check("b2b_odats", 32'(odats), 32'h1234);
        check("b2b_done_cnt", 32'(done_seen - d0), 32'd1);
        check("b2b_err_cnt", 32'(err_seen - e0), 32'd0);

        // False start: 3 low cycles
        d0 = done_seen; e0 = err_seen;
        uartrx = 1'b0;
        tick(3);
        uartrx = 1'b1;
        tick(40);
        check("false_start_odats", 32'(odats), 32'h1234);
        check("false_start_pulses", 32'(done_seen - d0 + err_seen - e0), 32'd0);

        // Framing error on second byte, then a clean packet
        d0 = done_seen; e0 = err_seen;
        send_byte(8'h12, 1'b1, -1);
        send_byte(8'h34, 1'b0, -1);
        idle_bits(2);
        check("frame_err_cnt", 32'(err_seen - e0), 32'd1);
        check("frame_err_done_cnt", 32'(done_seen - d0), 32'd0);
        check("frame_err_odats", 32'(odats), 32'h1234);
        send_byte(8'h56, 1'b1, -1);
        send_byte(8'h78, 1'b1, -1);
        idle_bits(2);
        check("after_err_odats", 32'(odats), 32'h5678);
        check("after_err_done_cnt", 32'(done_seen - d0), 32'd1);

        // Inter-byte timeout
        d0 = done_seen; e0 = err_seen;
        send_byte(8'hAB, 1'b1, -1);
        idle_bits(25);
        send_byte(8'hCD, 1'b1, -1);
        send_byte(8'hEF, 1'b1, -1);
        idle_bits(2);
        check("timeout_odats", 32'(odats), 32'hCDEF);
        check("timeout_done_cnt", 32'(done_seen - d0), 32'd1);
        check("timeout_err_cnt", 32'(err_seen - e0), 32'd0);

        // Reset during bit 4 of the second byte
        d0 = done_seen; e0 = err_seen;
        send_byte(8'h12, 1'b1, -1);
        send_byte(8'h34, 1'b1, 4);
        idle_bits(2);
        check("mid_reset_odats", 32'(odats), 32'h0);
        check("mid_reset_pulses", 32'(done_seen - d0 + err_seen - e0), 32'd0);
        send_byte(8'h55, 1'b1, -1);
        send_byte(8'hAA, 1'b1, -1);
        idle_bits(2);
        check("post_reset_odats", 32'(odats), 32'h55AA);

        // Eight packets with no gaps
        d0 = done_seen; e0 = err_seen;
        for (int k = 0; k < 8; k++) begin
            send_byte(8'h12, 1'b1, -1);
            send_byte(8'(8'h34 + k), 1'b1, -1);
        end
        idle_bits(2);
        check("burst_done_cnt", 32'(done_seen - d0), 32'd8);
        check("burst_last_odats", 32'(odats), 32'h123B);
        check("burst_err_cnt", 32'(err_seen - e0), 32'd0);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("err_exp_drained", 32'(err_exp), 32'd0);
        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rxs.md
UART_RXS -- requirements
Module: uart_rxs

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate.
REQ-003 SHALL have parameter BYTES, default 2, bytes per packet; legal range 1..4.
REQ-004 SHALL have parameter TIMEOUT_BITS, default 20, inter-byte idle limit in bit times.
REQ-005 SHALL have port sys_clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-007 SHALL have port uartrx, input, 1, asynchronous serial line, 8N1, idle high.
REQ-008 SHALL have port odats, output, BYTES*8, last complete packet.
REQ-009 SHALL have port uart_rxs_done, output, 1, one-cycle pulse when odats is updated.
REQ-010 SHALL have port rx_err, output, 1, one-cycle pulse on a framing error.

Function
REQ-011 SHALL define BIT_CYCLES = CLK_FREQ/BAUD (integer division) and HALF = BIT_CYCLES/2.
REQ-012 SHALL pass uartrx through a 2-flop synchronizer, preset to 1; all decoding uses the synchronized value.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-014 IDLE -> START on a synchronized 1->0 transition; bit counter cleared.
REQ-015 START: sample at count HALF-1; line 0 -> DATA; line 1 -> IDLE (false start, no error, byte count unchanged).
REQ-016 DATA: sample every BIT_CYCLES after the start-bit sample; 8 samples, LSB first, into an 8-bit shift register; -> STOP after the 8th.
REQ-017 STOP: sample BIT_CYCLES after the 8th data sample; line 1 = valid byte; line 0 = framing error.
REQ-018 Valid byte SHALL be stored at packet position byte_cnt; the first byte received lands in odats[BYTES*8-1 -: 8] (MSB byte first).
REQ-019 On the valid final byte (byte_cnt == BYTES-1), odats SHALL load the whole assembled packet; uart_rxs_done SHALL pulse high for exactly one cycle, on the cycle after the stop sample, with odats valid on that same cycle; byte_cnt -> 0.
REQ-020 On a valid non-final byte, byte_cnt SHALL increment; odats and uart_rxs_done unchanged.
REQ-021 On a framing error, rx_err SHALL pulse for one cycle on the cycle after the stop sample; the partial packet is discarded; byte_cnt -> 0; odats unchanged.
REQ-022 The FSM SHALL return to IDLE directly after the stop sample, so a start bit following immediately after the stop bit is accepted (back-to-back bytes).
REQ-023 While in IDLE with byte_cnt != 0, an idle counter SHALL run; on reaching TIMEOUT_BITS*BIT_CYCLES it resets byte_cnt to 0, discards the partial packet, and raises neither uart_rxs_done nor rx_err.
REQ-024 The idle counter SHALL clear on every start-bit detection.
REQ-025 odats SHALL hold its value between uart_rxs_done pulses.
REQ-026 uart_rxs_done and rx_err SHALL never both be high in the same cycle.

Reset
REQ-027 rst_n low SHALL immediately force: FSM IDLE, all counters 0, odats 0, uart_rxs_done 0, rx_err 0, synchronizer flops 1.
REQ-028 Reset asserted mid-byte or mid-packet SHALL discard all partial data; after release the block waits for a fresh falling edge.
REQ-029 Reset deassertion SHALL not by itself produce a start detection, even if uartrx is low at release.

Verification (CLK_FREQ=1_000_000, BAUD=100_000, i.e. 10 cycles/bit; BYTES=2; TIMEOUT_BITS=20)
REQ-030 Bytes 0x12 then 0x34, back-to-back -> one uart_rxs_done pulse, odats=0x1234, rx_err never high.
REQ-031 uartrx low for 3 cycles, then high -> no state change beyond START; no pulses; odats unchanged.
REQ-032 0x12 good, then 0x34 with stop bit 0 -> rx_err single pulse, no done; then 0x56, 0x78 -> odats=0x5678.
REQ-033 0xAB, idle 25 bit times, then 0xCD, 0xEF -> exactly one done pulse, odats=0xCDEF.
REQ-034 rst_n pulsed low during bit 4 of the second byte of 0x1234 -> odats=0, no pulses; next packet 0x55AA -> odats=0x55AA.
REQ-035 Eight consecutive packets 0x1234..0x123B sent with no gaps -> eight done pulses, with odats matching each packet in order.
